// File: rtl/pkg_rpn.sv
// Shared types and defaults for the RPN stack controller and its operand stack.
package pkg_rpn;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        GRAVA   = 2'd2
    } estado_t;

    localparam int LARGURA_PADRAO      = 8;
    localparam int PROFUNDIDADE_PADRAO = 4;
    localparam int OP_W_PADRAO         = 3;

    // Pointer must represent 0..PROFUNDIDADE, hence one bit more than the index
    function automatic int largura_ptr(input int prof);
        return $clog2(prof) + 1;
    endfunction

endpackage

// File: rtl/pilha_rpn.sv
// Register-file LIFO: push at the pointer, indexed write-back, pointer inc/dec.
module pilha_rpn
    import pkg_rpn::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_limpar,
    input  logic                                  i_push,
    input  logic [LARGURA-1:0]                    i_dado,
    input  logic                                  i_grava,
    input  logic                                  i_dec,
    input  logic [$clog2(PROFUNDIDADE)-1:0]       i_idx,
    input  logic [LARGURA-1:0]                    i_resultado,
    output logic [LARGURA-1:0]                    o_topo,
    output logic [LARGURA-1:0]                    o_tos,
    output logic [LARGURA-1:0]                    o_nos,
    output logic [largura_ptr(PROFUNDIDADE)-1:0]  o_contagem
);

    localparam int PW = largura_ptr(PROFUNDIDADE);
    localparam int AW = PW - 1;

    logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
    logic [PW-1:0]      r_ptr;
    logic [AW-1:0]      w_idx_push;
    logic [AW-1:0]      w_idx_tos;
    logic [AW-1:0]      w_idx_nos;

    // Index arithmetic wraps modulo the depth, so a full stack still addresses correctly
    assign w_idx_push = r_ptr[AW-1:0];
    assign w_idx_tos  = r_ptr[AW-1:0] - AW'(1);
    assign w_idx_nos  = r_ptr[AW-1:0] - AW'(2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_limpar) begin
            r_ptr <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (i_grava && i_dec) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_idx_push] <= i_dado;
        end else if (i_grava) begin
            r_mem[i_idx] <= i_resultado;
        end
    end

    assign o_tos      = r_mem[w_idx_tos];
    assign o_nos      = r_mem[w_idx_nos];
    assign o_topo     = (r_ptr == '0) ? '0 : r_mem[w_idx_tos];
    assign o_contagem = r_ptr;

endmodule

// File: rtl/controlador_pilha_rpn.sv
// RPN sequencing controller: operand stack, ALU operand registers, error flags.
// Optional macro RPN_DUP_EN: execute with a single entry uses it as both operands.
module controlador_pilha_rpn
    import pkg_rpn::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int OP_W         = OP_W_PADRAO
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enter_pulso,
    input  logic                                  executar_pulso,
    input  logic                                  limpar_pulso,
    input  logic [LARGURA-1:0]                    dado_entrada,
    input  logic [OP_W-1:0]                       operacao,
    input  logic [LARGURA-1:0]                    alu_resultado,
    output logic [LARGURA-1:0]                    alu_a,
    output logic [LARGURA-1:0]                    alu_b,
    output logic [OP_W-1:0]                       alu_op,
    output logic [LARGURA-1:0]                    topo,
    output logic [largura_ptr(PROFUNDIDADE)-1:0]  contagem,
    output logic                                  ocupado,
    output logic                                  resultado_valido,
    output logic                                  erro_underflow,
    output logic                                  erro_overflow
);

    localparam int PW = largura_ptr(PROFUNDIDADE);
    localparam int AW = PW - 1;

    estado_t            r_estado, w_prox;
    logic [LARGURA-1:0] r_alu_a, r_alu_b;
    logic [OP_W-1:0]    r_alu_op;
    logic               r_resultado_valido, r_erro_underflow, r_erro_overflow;

    logic               w_push, w_grava, w_aceita, w_set_unf, w_set_ovf;
    logic               w_exec_ok, w_cheia, w_dec;
    logic [LARGURA-1:0] w_tos, w_nos, w_op_a;
    logic [PW-1:0]      w_cont;
    logic [AW-1:0]      w_idx;

    assign w_cheia = (w_cont == PW'(PROFUNDIDADE));

`ifdef RPN_DUP_EN
    assign w_exec_ok = (w_cont != '0);
    assign w_dec     = (w_cont >= PW'(2));
    assign w_op_a    = w_dec ? w_nos : w_tos;
`else
    assign w_exec_ok = (w_cont >= PW'(2));
    assign w_dec     = 1'b1;
    assign w_op_a    = w_nos;
`endif

    // Result lands in the next-of-stack slot, or slot 0 when a single entry was duplicated
    assign w_idx = w_dec ? (w_cont[AW-1:0] - AW'(2)) : '0;

    always_comb begin
        w_prox    = r_estado;
        w_push    = 1'b0;
        w_grava   = 1'b0;
        w_aceita  = 1'b0;
        w_set_unf = 1'b0;
        w_set_ovf = 1'b0;
        if (limpar_pulso) begin
            w_prox = OCIOSO;
        end else begin
            unique case (r_estado)
                OCIOSO: begin
                    if (executar_pulso) begin
                        if (w_exec_ok) begin
                            w_aceita = 1'b1;
                            w_prox   = EXECUTA;
                        end else begin
                            w_set_unf = 1'b1;
                        end
                    end else if (enter_pulso) begin
                        if (w_cheia) w_set_ovf = 1'b1;
                        else         w_push    = 1'b1;
                    end
                end
                EXECUTA: w_prox = GRAVA;
                GRAVA: begin
                    w_grava = 1'b1;
                    w_prox  = OCIOSO;
                end
                default: w_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado           <= OCIOSO;
            r_alu_a            <= '0;
            r_alu_b            <= '0;
            r_alu_op           <= '0;
            r_resultado_valido <= 1'b0;
            r_erro_underflow   <= 1'b0;
            r_erro_overflow    <= 1'b0;
        end else begin
            r_estado           <= w_prox;
            r_resultado_valido <= w_grava;
            if (w_aceita) begin
                r_alu_a  <= w_op_a;
                r_alu_b  <= w_tos;
                r_alu_op <= operacao;
            end
            if (limpar_pulso) begin
                r_erro_underflow <= 1'b0;
                r_erro_overflow  <= 1'b0;
            end else begin
                if (w_set_unf) r_erro_underflow <= 1'b1;
                if (w_set_ovf) r_erro_overflow  <= 1'b1;
            end
        end
    end

    pilha_rpn #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_pilha (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_limpar    (limpar_pulso),
        .i_push      (w_push),
        .i_dado      (dado_entrada),
        .i_grava     (w_grava),
        .i_dec       (w_dec),
        .i_idx       (w_idx),
        .i_resultado (alu_resultado),
        .o_topo      (topo),
        .o_tos       (w_tos),
        .o_nos       (w_nos),
        .o_contagem  (w_cont)
    );

    assign contagem         = w_cont;
    assign alu_a            = r_alu_a;
    assign alu_b            = r_alu_b;
    assign alu_op           = r_alu_op;
    assign ocupado          = (r_estado != OCIOSO);
    assign resultado_valido = r_resultado_valido;
    assign erro_underflow   = r_erro_underflow;
    assign erro_overflow    = r_erro_overflow;

endmodule
